// File: rtl/pipeline_pkg.sv
// Shared definitions for the compositor: overlay mode encodings and RGB565 field layout.
package pipeline_pkg;

    typedef enum logic [1:0] {
        MODE_BG_ONLY = 2'd0,
        MODE_OVERLAY = 2'd1,
        MODE_CHROMA  = 2'd2,
        MODE_BLEND   = 2'd3
    } overlay_mode_e;

    localparam int unsigned RGB_R_W   = 5;
    localparam int unsigned RGB_G_W   = 6;
    localparam int unsigned RGB_B_W   = 5;
    localparam int unsigned RGB_R_OFF = 11;
    localparam int unsigned RGB_G_OFF = 5;
    localparam int unsigned RGB_B_OFF = 0;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; a push at full is accepted only with a same-cycle pop.
module pixel_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_empty,
    output logic             o_full
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end

endmodule

// File: rtl/compositor_pipeline.sv
// Overlay compositor: maps bg pixels into fg space, requests fg data, and merges the two in input order.
module compositor_pipeline
    import pipeline_pkg::*;
#(
    parameter int unsigned PRECISION              = 12,
    parameter int unsigned RESOLUTION_X           = 1920,
    parameter int unsigned RESOLUTION_Y           = 1080,
    parameter int unsigned TRANSPARENCY_PRECISION = 3,
    parameter int unsigned FIFO_DEPTH             = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [PRECISION-1:0]                pixel_x,
    input  logic [PRECISION-1:0]                pixel_y,
    input  logic [15:0]                         bg_pixel_in,
    input  logic                                bg_pixel_ready,
    output logic signed [PRECISION:0]           fg_pixel_request_x,
    output logic signed [PRECISION:0]           fg_pixel_request_y,
    output logic                                fg_pixel_request_active,
    input  logic [15:0]                         fg_pixel_in,
    input  logic                                fg_pixel_ready,
    output logic [15:0]                         pixel_out,
    output logic [PRECISION-1:0]                pixel_x_out,
    output logic [PRECISION-1:0]                pixel_y_out,
    output logic                                pixel_ready_out,
    output logic                                overflow,
    input  logic [1:0]                          ctrl_overlay_mode,
    input  logic [1:0]                          ctrl_fg_scale,
    input  logic signed [PRECISION:0]           ctrl_fg_offset_x,
    input  logic signed [PRECISION:0]           ctrl_fg_offset_y,
    input  logic [TRANSPARENCY_PRECISION-1:0]   ctrl_fg_transparency,
    input  logic [PRECISION-1:0]                ctrl_fg_clip_left,
    input  logic [PRECISION-1:0]                ctrl_fg_clip_right,
    input  logic [PRECISION-1:0]                ctrl_fg_clip_top,
    input  logic [PRECISION-1:0]                ctrl_fg_clip_bottom,
    input  logic [15:0]                         ctrl_green_screen_filter
);

    localparam int unsigned TP = TRANSPARENCY_PRECISION;
    localparam int unsigned EW = 16 + 2*PRECISION + 2 + TP + 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 2;

    // Per-channel weighted mix; channels are blended separately so no carry crosses fields.
    function automatic logic [5:0] blend_ch(input logic [5:0] f, input logic [5:0] b,
                                            input logic [TP-1:0] t);
        logic [TP:0]   wf;
        logic [TP+6:0] acc;
        wf  = {1'b1, {TP{1'b0}}} - {1'b0, t};
        acc = (TP+7)'(f) * (TP+7)'(wf) + (TP+7)'(b) * (TP+7)'(t);
        return 6'(acc >> TP);
    endfunction

    logic signed [PRECISION:0]   w_dx, w_dy, w_rel_x, w_rel_y;
    logic [PRECISION+1:0]        w_res_x, w_res_y;
    logic signed [PRECISION+1:0] w_lim_x, w_lim_y, w_relx_ext, w_rely_ext;
    logic                        w_vis_x, w_vis_y, w_needs_fg;
    logic                        w_pix_push, w_pix_empty, w_pix_full, w_req;
    logic                        w_fg_accept, w_fg_push, w_fg_empty, w_fg_full, w_fg_pop;
    logic                        w_pop;
    logic [EW-1:0]               w_pix_din, w_pix_dout;
    logic [15:0]                 w_fg_dout;
    logic [15:0]                 w_h_bg;
    logic [PRECISION-1:0]        w_h_x, w_h_y;
    logic [1:0]                  w_h_mode;
    logic [TP-1:0]               w_h_t;
    logic                        w_h_nf;
    logic [15:0]                 w_blend, w_result;

    logic [CW-1:0]               r_outstanding;
    logic                        r_req_active;
    logic signed [PRECISION:0]   r_req_x, r_req_y;
    logic [15:0]                 r_pixel_out;
    logic [PRECISION-1:0]        r_x_out, r_y_out;
    logic                        r_ready_out;
    logic                        r_overflow;

    assign w_dx    = $signed({1'b0, pixel_x}) - ctrl_fg_offset_x;
    assign w_dy    = $signed({1'b0, pixel_y}) - ctrl_fg_offset_y;
    assign w_rel_x = w_dx >>> ctrl_fg_scale;
    assign w_rel_y = w_dy >>> ctrl_fg_scale;

    assign w_res_x    = (PRECISION+2)'(RESOLUTION_X) >> ctrl_fg_scale;
    assign w_res_y    = (PRECISION+2)'(RESOLUTION_Y) >> ctrl_fg_scale;
    assign w_lim_x    = $signed(w_res_x) - $signed({2'b00, ctrl_fg_clip_right});
    assign w_lim_y    = $signed(w_res_y) - $signed({2'b00, ctrl_fg_clip_bottom});
    assign w_relx_ext = {w_rel_x[PRECISION], w_rel_x};
    assign w_rely_ext = {w_rel_y[PRECISION], w_rel_y};

    assign w_vis_x = !w_rel_x[PRECISION]
                  && (w_relx_ext >= $signed({2'b00, ctrl_fg_clip_left}))
                  && (w_relx_ext < w_lim_x);
    assign w_vis_y = !w_rel_y[PRECISION]
                  && (w_rely_ext >= $signed({2'b00, ctrl_fg_clip_top}))
                  && (w_rely_ext < w_lim_y);
    assign w_needs_fg = w_vis_x && w_vis_y && (ctrl_overlay_mode != MODE_BG_ONLY);

    assign {w_h_bg, w_h_x, w_h_y, w_h_mode, w_h_t, w_h_nf} = w_pix_dout;

    assign w_pop       = !w_pix_empty && (!w_h_nf || !w_fg_empty);
    assign w_fg_pop    = w_pop && w_h_nf;
    assign w_pix_push  = bg_pixel_ready && (!w_pix_full || w_pop);
    assign w_req       = w_pix_push && w_needs_fg;
    assign w_fg_accept = fg_pixel_ready && (r_outstanding != '0);
    assign w_fg_push   = w_fg_accept && (!w_fg_full || w_fg_pop);

    assign w_pix_din = {bg_pixel_in, pixel_x, pixel_y, ctrl_overlay_mode,
                        ctrl_fg_transparency, w_needs_fg};

    pixel_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_pix_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_pix_push),
        .i_pop   (w_pop),
        .i_data  (w_pix_din),
        .o_data  (w_pix_dout),
        .o_empty (w_pix_empty),
        .o_full  (w_pix_full)
    );

    pixel_fifo #(.WIDTH(16), .DEPTH(FIFO_DEPTH)) u_fg_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_fg_push),
        .i_pop   (w_fg_pop),
        .i_data  (fg_pixel_in),
        .o_data  (w_fg_dout),
        .o_empty (w_fg_empty),
        .o_full  (w_fg_full)
    );

    assign w_blend = {5'(blend_ch({1'b0, w_fg_dout[RGB_R_OFF +: RGB_R_W]},
                                  {1'b0, w_h_bg[RGB_R_OFF +: RGB_R_W]}, w_h_t)),
                      6'(blend_ch(w_fg_dout[RGB_G_OFF +: RGB_G_W],
                                  w_h_bg[RGB_G_OFF +: RGB_G_W], w_h_t)),
                      5'(blend_ch({1'b0, w_fg_dout[RGB_B_OFF +: RGB_B_W]},
                                  {1'b0, w_h_bg[RGB_B_OFF +: RGB_B_W]}, w_h_t))};

    always_comb begin
        w_result = w_h_bg;
        if (w_h_nf) begin
            case (overlay_mode_e'(w_h_mode))
                MODE_BG_ONLY: w_result = w_h_bg;
                MODE_OVERLAY: w_result = w_fg_dout;
                MODE_CHROMA:  w_result = (w_fg_dout == ctrl_green_screen_filter) ? w_h_bg : w_fg_dout;
                MODE_BLEND:   w_result = w_blend;
                default:      w_result = w_h_bg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
            r_req_active  <= 1'b0;
            r_req_x       <= '0;
            r_req_y       <= '0;
            r_pixel_out   <= '0;
            r_x_out       <= '0;
            r_y_out       <= '0;
            r_ready_out   <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_req) - CW'(w_fg_accept);
            r_req_active  <= w_req;
            if (w_req) begin
                r_req_x <= w_rel_x;
                r_req_y <= w_rel_y;
            end
            r_ready_out <= w_pop;
            if (w_pop) begin
                r_pixel_out <= w_result;
                r_x_out     <= w_h_x;
                r_y_out     <= w_h_y;
            end
            if ((bg_pixel_ready && !w_pix_push) || (w_fg_accept && !w_fg_push))
                r_overflow <= 1'b1;
        end
    end

    assign fg_pixel_request_active = r_req_active;
    assign fg_pixel_request_x      = r_req_x;
    assign fg_pixel_request_y      = r_req_y;
    assign pixel_out               = r_pixel_out;
    assign pixel_x_out             = r_x_out;
    assign pixel_y_out             = r_y_out;
    assign pixel_ready_out         = r_ready_out;
    assign overflow                = r_overflow;

endmodule

// File: tb/tb_compositor_pipeline.sv
// Directed bench for compositor_pipeline with hand-computed expectations.
module tb_compositor_pipeline;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [11:0]        pixel_x, pixel_y;
    logic [15:0]        bg_pixel_in;
    logic               bg_pixel_ready;
    logic signed [12:0] fg_pixel_request_x, fg_pixel_request_y;
    logic               fg_pixel_request_active;
    logic [15:0]        fg_pixel_in;
    logic               fg_pixel_ready;
    logic [15:0]        pixel_out;
    logic [11:0]        pixel_x_out, pixel_y_out;
    logic               pixel_ready_out;
    logic               overflow;
    logic [1:0]         ctrl_overlay_mode;
    logic [1:0]         ctrl_fg_scale;
    logic signed [12:0] ctrl_fg_offset_x, ctrl_fg_offset_y;
    logic [2:0]         ctrl_fg_transparency;
    logic [11:0]        ctrl_fg_clip_left, ctrl_fg_clip_right, ctrl_fg_clip_top, ctrl_fg_clip_bottom;
    logic [15:0]        ctrl_green_screen_filter;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    compositor_pipeline #(
        .PRECISION              (12),
        .RESOLUTION_X           (1920),
        .RESOLUTION_Y           (1080),
        .TRANSPARENCY_PRECISION (3),
        .FIFO_DEPTH             (8)
    ) dut (
        .clk                      (clk),
        .rst_n                    (rst_n),
        .pixel_x                  (pixel_x),
        .pixel_y                  (pixel_y),
        .bg_pixel_in              (bg_pixel_in),
        .bg_pixel_ready           (bg_pixel_ready),
        .fg_pixel_request_x       (fg_pixel_request_x),
        .fg_pixel_request_y       (fg_pixel_request_y),
        .fg_pixel_request_active  (fg_pixel_request_active),
        .fg_pixel_in              (fg_pixel_in),
        .fg_pixel_ready           (fg_pixel_ready),
        .pixel_out                (pixel_out),
        .pixel_x_out              (pixel_x_out),
        .pixel_y_out              (pixel_y_out),
        .pixel_ready_out          (pixel_ready_out),
        .overflow                 (overflow),
        .ctrl_overlay_mode        (ctrl_overlay_mode),
        .ctrl_fg_scale            (ctrl_fg_scale),
        .ctrl_fg_offset_x         (ctrl_fg_offset_x),
        .ctrl_fg_offset_y         (ctrl_fg_offset_y),
        .ctrl_fg_transparency     (ctrl_fg_transparency),
        .ctrl_fg_clip_left        (ctrl_fg_clip_left),
        .ctrl_fg_clip_right       (ctrl_fg_clip_right),
        .ctrl_fg_clip_top         (ctrl_fg_clip_top),
        .ctrl_fg_clip_bottom      (ctrl_fg_clip_bottom),
        .ctrl_green_screen_filter (ctrl_green_screen_filter)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one bg pixel for one clock; returns just after the capturing edge.
    task automatic send_bg(input logic [11:0] x, input logic [11:0] y, input logic [15:0] bg);
        pixel_x        = x;
        pixel_y        = y;
        bg_pixel_in    = bg;
        bg_pixel_ready = 1'b1;
        step();
        bg_pixel_ready = 1'b0;
    endtask

    task automatic send_fg(input logic [15:0] d);
        fg_pixel_in    = d;
        fg_pixel_ready = 1'b1;
        step();
        fg_pixel_ready = 1'b0;
    endtask

    initial begin
        int nreq;
        int k;

        rst_n                    = 1'b0;
        pixel_x                  = '0;
        pixel_y                  = '0;
        bg_pixel_in              = '0;
        bg_pixel_ready           = 1'b0;
        fg_pixel_in              = '0;
        fg_pixel_ready           = 1'b0;
        ctrl_overlay_mode        = 2'd0;
        ctrl_fg_scale            = 2'd0;
        ctrl_fg_offset_x         = '0;
        ctrl_fg_offset_y         = '0;
        ctrl_fg_transparency     = '0;
        ctrl_fg_clip_left        = '0;
        ctrl_fg_clip_right       = '0;
        ctrl_fg_clip_top         = '0;
        ctrl_fg_clip_bottom      = '0;
        ctrl_green_screen_filter = '0;
        step(); step(); step();
        chk("rst_ready",    32'(pixel_ready_out), 32'd0);
        chk("rst_pixel",    32'(pixel_out), 32'd0);
        chk("rst_req",      32'(fg_pixel_request_active), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        #2 rst_n = 1'b1;
        step();

        // Mode 0: background passes through, two-cycle latency, no request
        send_bg(12'd10, 12'd20, 16'hF800);
        chk("m0_no_req",   32'(fg_pixel_request_active), 32'd0);
        chk("m0_early",    32'(pixel_ready_out), 32'd0);
        step();
        chk("m0_ready",    32'(pixel_ready_out), 32'd1);
        chk("m0_pixel",    32'(pixel_out), 32'hF800);
        chk("m0_x",        32'(pixel_x_out), 32'd10);
        chk("m0_y",        32'(pixel_y_out), 32'd20);
        step();
        chk("m0_one_shot", 32'(pixel_ready_out), 32'd0);

        // Mode 1 with offset and scale
        ctrl_overlay_mode = 2'd1;
        ctrl_fg_offset_x  = 13'sd100;
        ctrl_fg_offset_y  = 13'sd50;
        ctrl_fg_scale     = 2'd1;
        send_bg(12'd300, 12'd150, 16'h1111);
        chk("m1_req",      32'(fg_pixel_request_active), 32'd1);
        chk("m1_req_x",    32'(fg_pixel_request_x), 32'd100);
        chk("m1_req_y",    32'(fg_pixel_request_y), 32'd50);
        ctrl_fg_offset_x  = '0;
        ctrl_fg_offset_y  = '0;
        ctrl_fg_scale     = 2'd0;
        step();
        chk("m1_req_pulse", 32'(fg_pixel_request_active), 32'd0);
        step();
        chk("m1_wait_fg",  32'(pixel_ready_out), 32'd0);
        send_fg(16'h001F);
        chk("m1_not_yet",  32'(pixel_ready_out), 32'd0);
        step();
        chk("m1_ready",    32'(pixel_ready_out), 32'd1);
        chk("m1_pixel",    32'(pixel_out), 32'h001F);
        chk("m1_x",        32'(pixel_x_out), 32'd300);
        chk("m1_y",        32'(pixel_y_out), 32'd150);

        // Mode 2 chroma key
        ctrl_overlay_mode        = 2'd2;
        ctrl_green_screen_filter = 16'h07E0;
        send_bg(12'd5, 12'd5, 16'hABCD);
        chk("m2_req",      32'(fg_pixel_request_active), 32'd1);
        send_fg(16'h07E0);
        step();
        chk("m2_key_hit",  32'(pixel_out), 32'hABCD);
        send_bg(12'd6, 12'd5, 16'hABCD);
        send_fg(16'h1234);
        step();
        chk("m2_key_miss", 32'(pixel_out), 32'h1234);

        // Mode 3 blend; transparency is latched with the pixel
        ctrl_overlay_mode    = 2'd3;
        ctrl_fg_transparency = 3'd4;
        send_bg(12'd1, 12'd1, 16'h0000);
        ctrl_fg_transparency = 3'd0;
        send_fg(16'hFFFF);
        step();
        chk("m3_t4",       32'(pixel_out), 32'h7BEF);
        send_bg(12'd2, 12'd1, 16'h0000);
        send_fg(16'hFFFF);
        step();
        chk("m3_t0",       32'(pixel_out), 32'hFFFF);
        ctrl_fg_transparency = 3'd7;
        send_bg(12'd3, 12'd1, 16'h001F);
        send_fg(16'hF800);
        step();
        chk("m3_t7",       32'(pixel_out), 32'h181B);

        // Visibility boundaries in overlay mode
        ctrl_overlay_mode    = 2'd1;
        ctrl_fg_transparency = 3'd0;
        ctrl_fg_clip_left    = 12'd50;
        send_bg(12'd10, 12'd0, 16'h2222);
        chk("clip_no_req", 32'(fg_pixel_request_active), 32'd0);
        step();
        chk("clip_bg",     32'(pixel_out), 32'h2222);
        ctrl_fg_clip_left    = 12'd0;
        ctrl_fg_offset_x     = 13'sd20;
        send_bg(12'd10, 12'd0, 16'h3333);
        chk("neg_no_req",  32'(fg_pixel_request_active), 32'd0);
        step();
        chk("neg_bg",      32'(pixel_out), 32'h3333);
        ctrl_fg_offset_x     = '0;
        send_bg(12'd1919, 12'd0, 16'h4444);
        chk("edge_req",    32'(fg_pixel_request_active), 32'd1);
        send_fg(16'h5555);
        step();
        chk("edge_fg",     32'(pixel_out), 32'h5555);
        send_bg(12'd1920, 12'd0, 16'h6666);
        chk("past_no_req", 32'(fg_pixel_request_active), 32'd0);
        step();
        chk("past_bg",     32'(pixel_out), 32'h6666);
        step();

        // Fill the pixel FIFO while fg is held back; the ninth pixel is dropped
        nreq = 0;
        for (int i = 0; i < 9; i++) begin
            pixel_x        = 12'(i);
            pixel_y        = 12'd7;
            bg_pixel_in    = 16'hB000 + 16'(i);
            bg_pixel_ready = 1'b1;
            step();
            if (fg_pixel_request_active) nreq++;
        end
        bg_pixel_ready = 1'b0;
        chk("ovf_requests", 32'(nreq), 32'd8);
        chk("ovf_flag",     32'(overflow), 32'd1);
        k = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 8) begin
                fg_pixel_in    = 16'h0100 + 16'(c);
                fg_pixel_ready = 1'b1;
            end else begin
                fg_pixel_ready = 1'b0;
            end
            step();
            if (pixel_ready_out) begin
                chk("ovf_order_pix", 32'(pixel_out), 32'h0100 + 32'(k));
                chk("ovf_order_x",   32'(pixel_x_out), 32'(k));
                k++;
            end
        end
        chk("ovf_out_count", 32'(k), 32'd8);
        chk("ovf_sticky",    32'(overflow), 32'd1);

        // Reset with requests pending, then a stray fg beat
        send_bg(12'd1, 12'd2, 16'h7777);
        send_bg(12'd2, 12'd2, 16'h7777);
        send_bg(12'd3, 12'd2, 16'h7777);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req",   32'(fg_pixel_request_active), 32'd0);
        chk("mid_rst_req_x", 32'(fg_pixel_request_x), 32'd0);
        chk("mid_rst_pixel", 32'(pixel_out), 32'd0);
        chk("mid_rst_x",     32'(pixel_x_out), 32'd0);
        chk("mid_rst_ready", 32'(pixel_ready_out), 32'd0);
        chk("mid_rst_ovf",   32'(overflow), 32'd0);
        #2 rst_n = 1'b1;
        step();
        fg_pixel_in    = 16'hDEAD;
        fg_pixel_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("stray_no_out", 32'(pixel_ready_out), 32'd0);
        end
        fg_pixel_ready = 1'b0;
        step();
        chk("stray_ready", 32'(pixel_ready_out), 32'd0);
        chk("stray_ovf",   32'(overflow), 32'd0);
        send_bg(12'd7, 12'd7, 16'h1111);
        send_fg(16'h5A5A);
        step();
        chk("post_rst_ready", 32'(pixel_ready_out), 32'd1);
        chk("post_rst_pixel", 32'(pixel_out), 32'h5A5A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
